// File: rtl/seq_serializer.sv
// Parallel-to-serial converter feeding a downstream sequence detector.
// One-word holding buffer in front of a shift register keeps the bit stream gap-free.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             out,
  output logic             out_valid,
  output logic             word_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hbuf_q, hbuf_d;
  logic             hfull_q, hfull_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept_s;
  logic             load_s;
  logic             last_s;

  // Move the register one position toward whichever end feeds the output.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {v[WIDTH-2:0], 1'b0};
    end else begin
      r = {1'b0, v[WIDTH-1:1]};
    end
    return r;
  endfunction

  assign din_ready = reset & ~hfull_q;
  assign accept_s  = din_valid & din_ready;
  assign last_s    = (cnt_q == CNT_LAST);

  // Shift engine next-state logic.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && hfull_q) begin
          load_s  = 1'b1;
          sreg_d  = hbuf_q;
          cnt_d   = {CW{1'b0}};
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (!en) begin
          state_d = SHIFT;
        end else if (!last_s) begin
          sreg_d = shift_one(sreg_q);
          cnt_d  = cnt_q + CW'(1);
        end else if (hfull_q) begin
          // Back-to-back reload so the next word follows with no idle cycle.
          load_s  = 1'b1;
          sreg_d  = hbuf_q;
          cnt_d   = {CW{1'b0}};
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding buffer: a new transfer wins over the drain caused by a load.
  always_comb begin
    hbuf_d  = hbuf_q;
    hfull_d = hfull_q;
    if (accept_s) begin
      hbuf_d  = din;
      hfull_d = 1'b1;
    end else if (load_s) begin
      hfull_d = 1'b0;
    end else begin
      hfull_d = hfull_q;
    end
  end

  // Serial outputs, valid only while the engine is shifting and enabled.
  always_comb begin
    out_valid = 1'b0;
    out       = 1'b0;
    word_done = 1'b0;
    if (state_q == SHIFT && en) begin
      out_valid = 1'b1;
      out       = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
      word_done = last_s;
    end else begin
      out_valid = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= {WIDTH{1'b0}};
      hbuf_q  <= {WIDTH{1'b0}};
      hfull_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      hbuf_q  <= hbuf_d;
      hfull_q <= hfull_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed and random self-checking bench for seq_serializer (MSB-first and LSB-first instances).
module tb_seq_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       en;
  logic       out;
  logic       out_valid;
  logic       word_done;

  logic [7:0] din2;
  logic       din_valid2;
  logic       din_ready2;
  logic       en2;
  logic       out2;
  logic       out_valid2;
  logic       word_done2;

  int n_tests;
  int n_fail;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .en(en), .out(out), .out_valid(out_valid), .word_done(word_done)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .din(din2), .din_valid(din_valid2), .din_ready(din_ready2),
    .en(en2), .out(out2), .out_valid(out_valid2), .word_done(word_done2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e;
    logic       rdy;
    logic       ov;
    logic       o;
    logic       wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic e, logic rdy, logic ov, logic o, logic wd);
    vec_t t;
    t.v = v; t.d = d; t.e = e; t.rdy = rdy; t.ov = ov; t.o = o; t.wd = wd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step_main(input logic v, input logic [7:0] d, input logic e);
    @(negedge clk);
    din_valid = v;
    din       = d;
    en        = e;
    #1;
  endtask

  // Pulse one word into an idle block, collect its serial bits and check timing.
  task automatic send_collect(input logic [7:0] w, input string nm);
    logic [7:0] bits;
    int         n;
    int         first_k;
    int         wd_k;
    bits = 8'h00; n = 0; first_k = -1; wd_k = -1;
    step_main(1'b1, w, 1'b1);
    chk({nm, "_ready"}, {31'd0, din_ready}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      step_main(1'b0, 8'h00, 1'b1);
      if (out_valid) begin
        bits = {bits[6:0], out};
        n++;
        if (first_k < 0) first_k = k;
        if (word_done) wd_k = k;
      end
    end
    chk({nm, "_bits"}, {24'd0, bits}, {24'd0, w});
    chk({nm, "_nbits"}, n, 32'd8);
    chk({nm, "_latency"}, first_k, 32'd1);
    chk({nm, "_wd_pos"}, wd_k, 32'd8);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  acc;
    logic [7:0]  bits2;
    logic [7:0]  pair_words[2];
    logic [15:0] pair_bits;
    logic [11:0] rdy_log;
    int          nb;
    int          nwords;
    int          qmax;
    int          wi;
    int          n_ov;
    int          first_ov;
    int          last_ov;
    int          k2;

    n_tests = 0; n_fail = 0;
    clk = 1'b0; reset = 1'b0;
    din = 8'hAA; din_valid = 1'b1; en = 1'b1;
    din2 = 8'h00; din_valid2 = 1'b0; en2 = 1'b1;

    // Reset state with inputs active.
    #12;
    chk("rst_ready", {31'd0, din_ready}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {31'd0, out}, 32'd0);
    chk("rst_wd", {31'd0, word_done}, 32'd0);
    din_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, din_ready}, 32'd1);

    // D6 single pulse.
    tbl.push_back(mk(1'b1, 8'hD6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    // D6 with en low for 3 cycles after the 4th bit.
    tbl.push_back(mk(1'b1, 8'hD6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    // Word held while en low in IDLE; a second din while full is ignored.
    tbl.push_back(mk(1'b1, 8'hD6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      step_main(tbl[i].v, tbl[i].d, tbl[i].e);
      chk($sformatf("vec%0d_ready", i), {31'd0, din_ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("vec%0d_ov", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("vec%0d_out", i), {31'd0, out}, {31'd0, tbl[i].o});
      chk($sformatf("vec%0d_wd", i), {31'd0, word_done}, {31'd0, tbl[i].wd});
    end

    // Back-to-back words D6, B5 with din_valid held high.
    pair_words[0] = 8'hD6; pair_words[1] = 8'hB5;
    wi = 0; n_ov = 0; first_ov = -1; last_ov = -1; pair_bits = 16'h0000; rdy_log = 12'h000;
    for (int k = 0; k < 24; k++) begin
      if (wi < 2) step_main(1'b1, pair_words[wi], 1'b1);
      else        step_main(1'b0, 8'h00, 1'b1);
      if (k < 12) rdy_log = {rdy_log[10:0], din_ready};
      if (wi < 2 && din_ready) wi++;
      if (out_valid) begin
        pair_bits = {pair_bits[14:0], out};
        n_ov++;
        if (first_ov < 0) first_ov = k;
        last_ov = k;
      end
    end
    chk("pair_bits", {16'd0, pair_bits}, 32'h0000D6B5);
    chk("pair_nov", n_ov, 32'd16);
    chk("pair_contig", last_ov - first_ov, 32'd15);
    chk("pair_ready_log", {20'd0, rdy_log}, 32'h00000A03);

    // LSB-first instance with 0B: bits 1,1,0,1,0,0,0,0.
    @(negedge clk); din_valid2 = 1'b1; din2 = 8'h0B; en2 = 1'b1;
    bits2 = 8'h00; n_ov = 0; k2 = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); din_valid2 = 1'b0; din2 = 8'h00;
      #1;
      if (out_valid2) begin
        bits2 = {bits2[6:0], out2};
        n_ov++;
        if (word_done2) k2 = n_ov;
      end
    end
    chk("lsb_bits", {24'd0, bits2}, 32'h000000D0);
    chk("lsb_nbits", n_ov, 32'd8);
    chk("lsb_wd_pos", k2, 32'd8);

    // Reset mid-word with a second word buffered.
    step_main(1'b1, 8'hD6, 1'b1);
    step_main(1'b0, 8'h00, 1'b1);
    step_main(1'b1, 8'h3C, 1'b1);
    chk("mid_accept2", {31'd0, din_ready}, 32'd1);
    chk("mid_bit1", {30'd0, out_valid, out}, 32'd3);
    for (int k = 0; k < 4; k++) step_main(1'b0, 8'h00, 1'b1);
    chk("mid_bit5", {30'd0, out_valid, out}, 32'd2);
    @(negedge clk);
    din_valid = 1'b1; din = 8'hAA;
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, din_ready}, 32'd0);
    chk("mid_rst_out", {30'd0, out, word_done}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold_ov", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    din_valid = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step_main(1'b0, 8'h00, 1'b1);
      chk($sformatf("mid_residual%0d", k), {30'd0, out_valid, din_ready}, 32'd1);
    end
    send_collect(8'hF0, "after_rst_F0");
    send_collect(8'h81, "single_81");

    // Random din_valid / en with a scoreboard of accepted words.
    acc = 8'h00; nb = 0; nwords = 0; qmax = 0;
    for (int c = 0; c < 10030; c++) begin
      @(negedge clk);
      if (c < 10000) begin
        din_valid = 1'($urandom_range(0, 1));
        din       = 8'($urandom);
        en        = ($urandom_range(0, 3) != 0);
      end else begin
        din_valid = 1'b0;
        en        = 1'b1;
      end
      #1;
      if (din_valid && din_ready) q.push_back(din);
      if (q.size() > qmax) qmax = q.size();
      if (out_valid) begin
        acc = {acc[6:0], out};
        chk("rnd_wd", {31'd0, word_done}, (nb == 7) ? 32'd1 : 32'd0);
        if (nb == 7) begin
          if (q.size() == 0) begin
            chk("rnd_underflow", 32'd0, 32'd1);
          end else begin
            chk("rnd_word", {24'd0, acc}, {24'd0, q.pop_front()});
          end
          nwords++;
          nb = 0;
        end else begin
          nb++;
        end
      end else if (out || word_done) begin
        chk("rnd_idle_out", {30'd0, out, word_done}, 32'd0);
      end
    end
    chk("rnd_drained", q.size(), 32'd0);
    chk("rnd_partial", nb, 32'd0);
    chk("rnd_qmax", (qmax <= 2) ? 32'd1 : 32'd0, 32'd1);
    chk("rnd_enough", (nwords > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter WIDTH, default 8, bits per parallel word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 shifted first, 0 = bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a valid word.
REQ-007 din_ready  output  1  block can accept din this cycle.
REQ-008 en  input  1  shift enable; 0 freezes the shift engine.
REQ-009 out  output  1  serial bit stream to the downstream sequence detector input.
REQ-010 out_valid  output  1  out carries a valid bit this cycle.
REQ-011 word_done  output  1  one-cycle pulse while the last bit of a word is presented.

Function
REQ-012 Datapath SHALL be a one-word holding buffer (hbuf, hfull), a WIDTH-bit shift register (sreg) and a bit counter cnt of width clog2(WIDTH).
REQ-013 din_ready SHALL equal ~hfull while reset is deasserted, and 0 while reset is asserted.
REQ-014 Transfer SHALL occur on a posedge where din_valid=1 and din_ready=1: hbuf<=din, hfull<=1.
REQ-015 din SHALL be ignored when din_valid=0 or din_ready=0; a held word is never overwritten.
REQ-016 Shift engine SHALL have two states, IDLE and SHIFT.
REQ-017 IDLE, hfull=1, en=1: sreg<=hbuf, cnt<=0, hfull<=0, next state SHIFT.
REQ-018 IDLE, hfull=0 or en=0: remain IDLE.
REQ-019 SHIFT, en=1, cnt<WIDTH-1: shift sreg by one toward the output end, cnt<=cnt+1.
REQ-020 SHIFT, en=1, cnt=WIDTH-1, hfull=1: sreg<=hbuf, cnt<=0, hfull<=0, remain SHIFT (no gap between words).
REQ-021 SHIFT, en=1, cnt=WIDTH-1, hfull=0: next state IDLE.
REQ-022 SHIFT, en=0: sreg, cnt and state SHALL hold.
REQ-023 A hbuf load by REQ-017/020 and a new transfer by REQ-014 on the same edge SHALL both take effect: hbuf takes din, hfull stays 1.
REQ-024 out_valid SHALL be 1 exactly when state=SHIFT and en=1.
REQ-025 out SHALL be sreg[WIDTH-1] if MSB_FIRST=1, else sreg[0], when out_valid=1; otherwise out SHALL be 0.
REQ-026 word_done SHALL be 1 exactly when out_valid=1 and cnt=WIDTH-1.
REQ-027 Latency: first bit of a word accepted at edge N into an empty, idle block SHALL appear with out_valid=1 in the cycle after edge N+1.
REQ-028 Throughput: with din_valid held high and en=1, out_valid SHALL stay high continuously across word boundaries.
REQ-029 Bit order within a word SHALL be preserved exactly; words SHALL be emitted in acceptance order, none dropped or duplicated.

Reset
REQ-030 While reset=0: state=IDLE, sreg=0, cnt=0, hbuf=0, hfull=0, out=0, out_valid=0, word_done=0, din_ready=0.
REQ-031 Reset assertion mid-word SHALL discard the partial word and any buffered word immediately, without waiting for clk.
REQ-032 First transfer SHALL be possible on the first posedge after reset rises to 1.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1, din=8'hD6 pulsed once, en=1 -> out = 1,1,0,1,0,1,1,0 on 8 consecutive out_valid cycles; word_done on the 8th; then IDLE.
REQ-034 din_valid held high with 8'hD6 then 8'hB5 -> 16 contiguous out_valid cycles, bits 11010110 10110101; din_ready low while hbuf is full.
REQ-035 MSB_FIRST=0, din=8'h0B -> out = 1,1,0,1,0,0,0,0 (1101 pattern first).
REQ-036 en dropped to 0 for 3 cycles after the 4th bit of 8'hD6 -> out_valid=0 for 3 cycles; remaining bits 0,1,1,0 resume unchanged; no bit lost or repeated.
REQ-037 reset pulsed low after the 5th bit with a second word buffered -> out_valid=0, din_ready=0 immediately; after release, no residual bits are emitted and a new word 8'hF0 serializes as 1,1,1,1,0,0,0,0.
REQ-038 Random din_valid and en over 10,000 cycles -> scoreboard confirms order and content of all accepted words, with no overflow.
